// File: rtl/ltssm_polling_fsm_if.sv
// ---------------------------------------------------------------------------
// ltssm_polling_fsm_if
//   Ordered-set transmit request channel between the Polling controller and
//   the ordered-set generator. The controller holds a request up while it
//   wants ordered sets sent. The generator accepts one ordered set in every
//   cycle where both valid and ready are high.
//
//   tx_os_valid    controller -> generator  request to send one ordered set
//   tx_os_type     controller -> generator  0 = TS1, 1 = TS2
//   tx_compliance  controller -> generator  send compliance pattern instead
//   tx_os_ready    generator  -> controller ordered set accepted this cycle
// ---------------------------------------------------------------------------
interface ltssm_polling_fsm_if;
  logic tx_os_valid;
  logic tx_os_type;
  logic tx_compliance;
  logic tx_os_ready;

  modport master (
    output tx_os_valid,
    output tx_os_type,
    output tx_compliance,
    input  tx_os_ready
  );

  modport slave (
    input  tx_os_valid,
    input  tx_os_type,
    input  tx_compliance,
    output tx_os_ready
  );
endinterface : ltssm_polling_fsm_if

// File: rtl/ltssm_polling_fsm.sv
// ---------------------------------------------------------------------------
// ltssm_polling_fsm
//   LTSSM Polling substate controller covering Polling.Active,
//   Polling.Compliance and Polling.Configuration. It runs for up to
//   MAX_NUM_LANES lanes. The top LTSSM starts it after Detect and holds
//   en_i high. The controller:
//     - requests TS1/TS2 ordered sets or the compliance pattern,
//     - counts consecutive received TS on each lane,
//     - runs the Active and Configuration timeouts,
//     - reports done_o with the surviving lane mask (go to Configuration),
//       or fail_o (go back to Detect).
//   All outputs are registered.
//
// Ports
//   clk_i, rst_ni       clock, asynchronous active-low reset
//   en_i                level enable; low aborts to IDLE on the next cycle
//   lanes_detected_i    receiver-detected lanes, sampled when leaving IDLE
//   rx_elec_idle_i      per-lane receiver electrical idle
//   rx_ts_valid_i       per-lane one-cycle pulse: a full TS was received
//   rx_ts_type_i        per-lane TS type (0 = TS1, 1 = TS2), qualified by valid
//   tx_os               ordered-set request channel (master side)
//   tx_elec_idle_o      per-lane TX electrical idle (1 on lanes outside mask)
//   active_lanes_o      current lane mask
//   state_o             encoded state, for debug
//   done_o / fail_o     sticky result levels, cleared when en_i goes low
// ---------------------------------------------------------------------------
module ltssm_polling_fsm #(
  parameter int MAX_NUM_LANES   = 4,
  parameter int TMO_ACTIVE_CYC  = 6000000,
  parameter int TMO_CONFIG_CYC  = 12000000,
  parameter int TS1_TX_MIN      = 1024,
  parameter int TS_RX_CONSEC    = 8,
  parameter int TS2_TX_AFTER_RX = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     en_i,
  input  logic [MAX_NUM_LANES-1:0] lanes_detected_i,
  input  logic [MAX_NUM_LANES-1:0] rx_elec_idle_i,
  input  logic [MAX_NUM_LANES-1:0] rx_ts_valid_i,
  input  logic [MAX_NUM_LANES-1:0] rx_ts_type_i,
  ltssm_polling_fsm_if.master      tx_os,
  output logic [MAX_NUM_LANES-1:0] tx_elec_idle_o,
  output logic [MAX_NUM_LANES-1:0] active_lanes_o,
  output logic [2:0]               state_o,
  output logic                     done_o,
  output logic                     fail_o
);

  localparam int N      = MAX_NUM_LANES;
  localparam int TW     = $clog2(TMO_CONFIG_CYC);
  localparam int TX_MAX = (TS1_TX_MIN > TS2_TX_AFTER_RX) ? TS1_TX_MIN : TS2_TX_AFTER_RX;
  localparam int CW     = $clog2(TX_MAX + 1);
  localparam int RW     = $clog2(TS_RX_CONSEC + 1);

  localparam logic [TW-1:0] TMO_A_LAST = TW'(TMO_ACTIVE_CYC - 1);
  localparam logic [TW-1:0] TMO_C_LAST = TW'(TMO_CONFIG_CYC - 1);
  localparam logic [CW-1:0] TS1_FULL   = CW'(TS1_TX_MIN);
  localparam logic [CW-1:0] TS2_FULL   = CW'(TS2_TX_AFTER_RX);
  localparam logic [RW-1:0] RX_FULL    = RW'(TS_RX_CONSEC);

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_ACTIVE     = 3'd1,
    ST_COMPLIANCE = 3'd2,
    ST_CONFIG     = 3'd3,
    ST_DONE       = 3'd4,
    ST_FAIL       = 3'd5
  } state_e;

  state_e               state_q, state_d;
  logic [N-1:0]         mask_q, mask_d;
  logic [TW-1:0]        timer_q, timer_d;
  logic [CW-1:0]        tx_cnt_q, tx_cnt_d;
  logic [N-1:0][RW-1:0] rx_cnt_q, rx_cnt_d;
  logic                 ts2_seen_q, ts2_seen_d;
  logic [N-1:0]         eidle_q;

  logic                 tx_valid_q, tx_valid_d;
  logic                 tx_type_q, tx_type_d;
  logic                 tx_comp_q, tx_comp_d;
  logic [N-1:0]         tx_eidle_q, tx_eidle_d;
  logic                 done_q, done_d;
  logic                 fail_q, fail_d;

  logic                 accept;
  logic [N-1:0]         lane_ok;
  logic                 all_ok;
  logic                 any_ok;

  assign accept = tx_valid_q & tx_os.tx_os_ready;

  always_comb begin
    lane_ok = '0;
    for (int l = 0; l < N; l++) begin
      lane_ok[l] = (rx_cnt_q[l] == RX_FULL);
    end
  end

  // Only lanes inside the mask take part. Lanes outside it count as "ok"
  // for the all-lanes test and never count as "ok" for the any-lane test.
  assign all_ok = ((lane_ok & mask_q) == mask_q);
  assign any_ok = |(lane_ok & mask_q);

  always_comb begin
    // NOTE: every signal written here gets a default first. Without that,
    // a path that skips an assignment would infer a latch.
    state_d    = state_q;
    mask_d     = mask_q;
    timer_d    = timer_q;
    tx_cnt_d   = tx_cnt_q;
    rx_cnt_d   = rx_cnt_q;
    ts2_seen_d = ts2_seen_q;

    unique case (state_q)
      ST_IDLE: begin
        if (en_i) begin
          mask_d     = lanes_detected_i;
          timer_d    = '0;
          tx_cnt_d   = '0;
          rx_cnt_d   = '0;
          ts2_seen_d = 1'b0;
          state_d    = (lanes_detected_i == '0) ? ST_FAIL : ST_ACTIVE;
        end
      end

      ST_ACTIVE: begin
        timer_d = timer_q + TW'(1);
        if (accept && (tx_cnt_q != TS1_FULL)) begin
          tx_cnt_d = tx_cnt_q + CW'(1);
        end
        // In Polling.Active a TS of either type counts toward the lane's total.
        for (int l = 0; l < N; l++) begin
          if (mask_q[l] && rx_ts_valid_i[l] && (rx_cnt_q[l] != RX_FULL)) begin
            rx_cnt_d[l] = rx_cnt_q[l] + RW'(1);
          end
        end

        // If normal exit and timeout happen in the same cycle, normal exit wins.
        if ((tx_cnt_q == TS1_FULL) && all_ok) begin
          state_d    = ST_CONFIG;
          timer_d    = '0;
          tx_cnt_d   = '0;
          rx_cnt_d   = '0;
          ts2_seen_d = 1'b0;
        end else if (timer_q == TMO_A_LAST) begin
          if (any_ok && (tx_cnt_q == TS1_FULL)) begin
            // Continue with the lanes that trained. The rest are dropped.
            state_d    = ST_CONFIG;
            mask_d     = mask_q & lane_ok;
            timer_d    = '0;
            tx_cnt_d   = '0;
            rx_cnt_d   = '0;
            ts2_seen_d = 1'b0;
          end else if (|(mask_q & rx_elec_idle_i)) begin
            state_d = ST_COMPLIANCE;
            timer_d = '0;
          end else begin
            state_d = ST_FAIL;
            mask_d  = '0;
          end
        end
      end

      ST_COMPLIANCE: begin
        // No timeout here. Leave when any masked lane exits electrical idle
        // (previous-cycle 1, now 0).
        if (|(mask_q & eidle_q & ~rx_elec_idle_i)) begin
          state_d    = ST_ACTIVE;
          timer_d    = '0;
          tx_cnt_d   = '0;
          rx_cnt_d   = '0;
          ts2_seen_d = 1'b0;
        end
      end

      ST_CONFIG: begin
        timer_d = timer_q + TW'(1);
        if (|(mask_q & rx_ts_valid_i & rx_ts_type_i)) begin
          ts2_seen_d = 1'b1;
        end
        // TS2 are counted only after the cycle in which the first TS2 arrived.
        if (accept && ts2_seen_q && (tx_cnt_q != TS2_FULL)) begin
          tx_cnt_d = tx_cnt_q + CW'(1);
        end
        // A TS1 breaks the run of consecutive TS2.
        for (int l = 0; l < N; l++) begin
          if (mask_q[l] && rx_ts_valid_i[l]) begin
            if (!rx_ts_type_i[l]) begin
              rx_cnt_d[l] = '0;
            end else if (rx_cnt_q[l] != RX_FULL) begin
              rx_cnt_d[l] = rx_cnt_q[l] + RW'(1);
            end
          end
        end

        if (all_ok && (tx_cnt_q == TS2_FULL)) begin
          state_d = ST_DONE;
        end else if (timer_q == TMO_C_LAST) begin
          state_d = ST_FAIL;
          mask_d  = '0;
        end
      end

      ST_DONE: ;
      ST_FAIL: ;

      default: begin
        state_d = ST_IDLE;
        mask_d  = '0;
      end
    endcase

    // Dropping the enable aborts from any state, including mid-sequence.
    if (!en_i) begin
      state_d    = ST_IDLE;
      mask_d     = '0;
      timer_d    = '0;
      tx_cnt_d   = '0;
      rx_cnt_d   = '0;
      ts2_seen_d = 1'b0;
    end

    // Outputs are decoded from the next state and registered with it.
    // As a result, type and compliance can only change on a state change.
    tx_valid_d = (state_d == ST_ACTIVE) || (state_d == ST_COMPLIANCE) ||
                 (state_d == ST_CONFIG);
    tx_type_d  = (state_d == ST_CONFIG);
    tx_comp_d  = (state_d == ST_COMPLIANCE);
    done_d     = (state_d == ST_DONE);
    fail_d     = (state_d == ST_FAIL);
    tx_eidle_d = ((state_d == ST_IDLE) || (state_d == ST_FAIL)) ? '1 : ~mask_d;
  end

  // NOTE: sequential state uses non-blocking assignments only. All registers
  // then update together at the clock edge, whatever order they appear in.
  // The per-lane counter array is small, so it is reset as well. That keeps
  // every output defined straight out of reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= ST_IDLE;
      mask_q     <= '0;
      timer_q    <= '0;
      tx_cnt_q   <= '0;
      rx_cnt_q   <= '0;
      ts2_seen_q <= 1'b0;
      eidle_q    <= '0;
      tx_valid_q <= 1'b0;
      tx_type_q  <= 1'b0;
      tx_comp_q  <= 1'b0;
      tx_eidle_q <= '1;
      done_q     <= 1'b0;
      fail_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      mask_q     <= mask_d;
      timer_q    <= timer_d;
      tx_cnt_q   <= tx_cnt_d;
      rx_cnt_q   <= rx_cnt_d;
      ts2_seen_q <= ts2_seen_d;
      eidle_q    <= rx_elec_idle_i;
      tx_valid_q <= tx_valid_d;
      tx_type_q  <= tx_type_d;
      tx_comp_q  <= tx_comp_d;
      tx_eidle_q <= tx_eidle_d;
      done_q     <= done_d;
      fail_q     <= fail_d;
    end
  end

  assign tx_os.tx_os_valid   = tx_valid_q;
  assign tx_os.tx_os_type    = tx_type_q;
  assign tx_os.tx_compliance = tx_comp_q;
  assign tx_elec_idle_o      = tx_eidle_q;
  assign active_lanes_o      = mask_q;
  assign state_o             = state_q;
  assign done_o              = done_q;
  assign fail_o              = fail_q;

endmodule : ltssm_polling_fsm
